l1b_lsu_addr_gen: RTL



---
 rtl/l1b_agen_pkg.sv | 23 ++
 rtl/l1b_agen_loop_cnt.sv | 56 +++++
 rtl/l1b_lsu_addr_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/l1b_agen_pkg.sv
// Shared types and default widths for the L1b LSU address generator.
package l1b_agen_pkg;

  localparam int unsigned AGEN_ADDR_WID   = 12;
  localparam int unsigned AGEN_CNT_WID    = 8;
  localparam int unsigned AGEN_STRIDE_WID = 12;

  typedef enum logic [1:0] {
    AGEN_IDLE = 2'd0,
    AGEN_RUN  = 2'd1,
    AGEN_DONE = 2'd2
  } agen_state_e;

  typedef struct packed {
    logic                       wr_en;
    logic [AGEN_ADDR_WID-1:0]   base;
    logic [AGEN_CNT_WID-1:0]    inner_num;
    logic [AGEN_CNT_WID-1:0]    outer_num;
    logic [AGEN_STRIDE_WID-1:0] inner_stride;
    logic [AGEN_STRIDE_WID-1:0] outer_stride;
  } agen_cmd_t;

endpackage

// File: rtl/l1b_agen_loop_cnt.sv
// 2-D beat counter: walks inner beats within a row, then steps to the next row base.
module l1b_agen_loop_cnt
  import l1b_agen_pkg::*;
#(
  parameter int unsigned ADDR_WID = AGEN_ADDR_WID,
  parameter int unsigned CNT_WID  = AGEN_CNT_WID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                advance,
  input  logic [ADDR_WID-1:0] base_addr,
  input  logic [CNT_WID-1:0]  inner_num,
  input  logic [CNT_WID-1:0]  outer_num,
  input  logic [ADDR_WID-1:0] inner_step,
  input  logic [ADDR_WID-1:0] outer_step,
  output logic [ADDR_WID-1:0] cur_addr,
  output logic                last
);

  logic [CNT_WID-1:0]  i_cnt;
  logic [CNT_WID-1:0]  o_cnt;
  logic [ADDR_WID-1:0] row_base;
  logic [ADDR_WID-1:0] cur;
  logic [ADDR_WID-1:0] row_next;

  assign row_next = row_base + outer_step;
  assign cur_addr = cur;
  assign last     = (i_cnt == inner_num) && (o_cnt == outer_num);

  // Load on command accept; advance one beat per issued address, wrapping modulo address width.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt    <= '0;
      o_cnt    <= '0;
      row_base <= '0;
      cur      <= '0;
    end else if (load) begin
      i_cnt    <= '0;
      o_cnt    <= '0;
      row_base <= base_addr;
      cur      <= base_addr;
    end else if (advance) begin
      if (i_cnt < inner_num) begin
        i_cnt <= i_cnt + CNT_WID'(1);
        cur   <= cur + inner_step;
      end else if (o_cnt < outer_num) begin
        i_cnt    <= '0;
        o_cnt    <= o_cnt + CNT_WID'(1);
        row_base <= row_next;
        cur      <= row_next;
      end
    end
  end

endmodule

// File: rtl/l1b_lsu_addr_gen.sv
// Sequences one 2-D LSU command into a per-cycle stream of quad-word addresses for the L1b map stage.
module l1b_lsu_addr_gen
  import l1b_agen_pkg::*;
#(
  parameter int unsigned LSU_SYS_ADDR_WID = AGEN_ADDR_WID,
  parameter int unsigned CNT_WID          = AGEN_CNT_WID,
  parameter int unsigned STRIDE_WID       = AGEN_STRIDE_WID
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_wr_en,
  input  logic [LSU_SYS_ADDR_WID-1:0] cmd_base_addr,
  input  logic [CNT_WID-1:0]          cmd_inner_num,
  input  logic [CNT_WID-1:0]          cmd_outer_num,
  input  logic [STRIDE_WID-1:0]       cmd_inner_stride,
  input  logic [STRIDE_WID-1:0]       cmd_outer_stride,
  input  logic                        cmd_abort,
  input  logic                        l1b_stall,
  output logic                        slsu_l1b_addr_valid,
  output logic                        slsu_l1b_wr_en,
  output logic [LSU_SYS_ADDR_WID-1:0] slsu_l1b_addr,
  output logic                        agen_busy,
  output logic                        agen_done
);

  agen_state_e state_q;
  agen_state_e state_d;
  logic        accept;
  logic        issue;
  logic        last;

  logic [CNT_WID-1:0]          inner_num_q;
  logic [CNT_WID-1:0]          outer_num_q;
  logic [STRIDE_WID-1:0]       inner_stride_q;
  logic [STRIDE_WID-1:0]       outer_stride_q;
  logic [LSU_SYS_ADDR_WID-1:0] cur_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= AGEN_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus accept/issue strobes; abort outranks stall, stall outranks issue.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      AGEN_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = AGEN_RUN;
        end
      end
      AGEN_RUN: begin
        if (cmd_abort) begin
          state_d = AGEN_IDLE;
        end else if (!l1b_stall) begin
          issue = 1'b1;
          if (last) state_d = AGEN_DONE;
        end
      end
      AGEN_DONE: state_d = AGEN_IDLE;
      default:   state_d = AGEN_IDLE;
    endcase
  end

  // Command latch: loop bounds and strides held for the life of the command.
  always_ff @(posedge clk) begin
    if (rst) begin
      inner_num_q    <= '0;
      outer_num_q    <= '0;
      inner_stride_q <= '0;
      outer_stride_q <= '0;
    end else if (accept) begin
      inner_num_q    <= cmd_inner_num;
      outer_num_q    <= cmd_outer_num;
      inner_stride_q <= cmd_inner_stride;
      outer_stride_q <= cmd_outer_stride;
    end
  end

  l1b_agen_loop_cnt #(
    .ADDR_WID (LSU_SYS_ADDR_WID),
    .CNT_WID  (CNT_WID)
  ) u_loop_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .advance    (issue),
    .base_addr  (cmd_base_addr),
    .inner_num  (inner_num_q),
    .outer_num  (outer_num_q),
    .inner_step (LSU_SYS_ADDR_WID'(inner_stride_q)),
    .outer_step (LSU_SYS_ADDR_WID'(outer_stride_q)),
    .cur_addr   (cur_addr),
    .last       (last)
  );

  // Beat output registers; address and write enable hold when no beat or command is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      slsu_l1b_addr_valid <= 1'b0;
      slsu_l1b_wr_en      <= 1'b0;
      slsu_l1b_addr       <= '0;
    end else begin
      slsu_l1b_addr_valid <= issue;
      if (issue)  slsu_l1b_addr  <= cur_addr;
      if (accept) slsu_l1b_wr_en <= cmd_wr_en;
    end
  end

  assign cmd_ready = (state_q == AGEN_IDLE);
  assign agen_busy = (state_q == AGEN_RUN) || (state_q == AGEN_DONE);
  assign agen_done = (state_q == AGEN_DONE);

endmodule
